// File: rtl/input_conditioner.sv
// Input conditioner: 2-FF synchroniser plus persistence filter per channel,
// with registered edge pulses and saturating glitch counters.
module input_conditioner #(
  parameter int                N_CH        = 4,
  parameter logic [N_CH-1:0]   RESET_LEVEL = 4'b1000,
  parameter int                CNT_W       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH-1:0]         raw_in,
  input  logic [CNT_W-1:0]        filter_len,
  input  logic                    glitch_clear,
  output logic [N_CH-1:0]         clean_out,
  output logic [N_CH-1:0]         rise_pulse,
  output logic [N_CH-1:0]         fall_pulse,
  output logic [N_CH*CNT_W-1:0]   glitch_count
);

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic             stable;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] glitch;
    logic             match;

    assign match = (sync2[ch] == stable);

    // cnt holds how many mismatching samples have been seen so far; a
    // return to the stable level with a nonzero count is a rejected glitch.
    always_ff @(posedge clock) begin
      if (reset) begin
        stable <= RESET_LEVEL[ch];
        rise   <= 1'b0;
        fall   <= 1'b0;
        cnt    <= '0;
        glitch <= '0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        if (match) begin
          cnt <= '0;
        end else if (cnt >= filter_len) begin
          stable <= sync2[ch];
          cnt    <= '0;
          rise   <= sync2[ch];
          fall   <= ~sync2[ch];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (glitch_clear) begin
          glitch <= '0;
        end else if (match && (cnt != '0) && (glitch != '1)) begin
          glitch <= glitch + CNT_W'(1);
        end
      end
    end

    assign clean_out[ch]                     = stable;
    assign rise_pulse[ch]                    = rise;
    assign fall_pulse[ch]                    = fall;
    assign glitch_count[ch*CNT_W +: CNT_W]   = glitch;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that turns the raw, asynchronous experiment inputs (start button, FG opto sensor, wire sensor, detector ready) into clean, synchronised, glitch-filtered levels for the experiment sequencer. Each channel has a 2-FF synchroniser and a programmable persistence filter. Each channel also produces one-cycle rise/fall pulses and a saturating glitch counter for diagnostics. It sits directly upstream of the sequencer and drives its input bundle; the counters are exported to the register block.

## Interface
Parameters:
- N_CH, 4, number of channels; order is start, fg_opto, wire_sensor, detector_ready.
- RESET_LEVEL, 4'b1000, per-channel idle level loaded at reset; detector_ready idles high.
- CNT_W, 16, width of the filter counter, filter_len and each glitch counter.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- raw_in  in  N_CH  asynchronous raw inputs.
- filter_len  in  CNT_W  persistence length in cycles, shared by all channels; sampled every cycle.
- glitch_clear  in  1  synchronous clear of all glitch counters.
- clean_out  out  N_CH  filtered levels.
- rise_pulse  out  N_CH  one-cycle pulse when clean_out goes 0→1.
- fall_pulse  out  N_CH  one-cycle pulse when clean_out goes 1→0.
- glitch_count  out  N_CH*CNT_W  per-channel counters, channel i at bits [i*CNT_W +: CNT_W].

## Operation
- Synchroniser: sync1 <= raw_in, then sync2 <= sync1. Both stages reset to RESET_LEVEL.
- Per-channel filter state: stable (drives clean_out) and cnt.
- Match (sync2 == stable): cnt <= 0.
  - If cnt was nonzero in that cycle, the glitch counter increments.
- Mismatch (sync2 != stable), with cnt >= filter_len: stable <= sync2, cnt <= 0, and the matching rise or fall pulse is asserted for that one cycle.
- Mismatch, with cnt < filter_len: cnt <= cnt + 1.
- Pulses are registered together with stable, so a pulse and the new clean_out level appear in the same cycle.
- filter_len = 0: every level change seen at sync2 is accepted on its first cycle. No glitches are possible.
- filter_len changed mid-count: the new value applies immediately. If cnt >= new value, the change is accepted on the next mismatch cycle.
- Glitch counters saturate at 2^CNT_W-1 and never wrap.
- glitch_clear has priority over an increment in the same cycle; the counter reads 0 the next cycle.
- A channel with sustained toggling faster than filter_len never changes clean_out and accumulates glitches.
- Reset:
  - sync1, sync2, stable and clean_out go to RESET_LEVEL.
  - cnt, pulses and glitch counters go to 0.
  - No pulse is emitted on reset release, even if raw_in differs from RESET_LEVEL; the change then filters normally.
- Reset mid-filter discards the partial count and does not count a glitch.

## Timing
- Latency from raw_in change to clean_out/pulse: filter_len + 3 cycles (2 synchroniser + filter_len + 1 register stage).
- A raw pulse is accepted iff it stays stable at sync2 for filter_len+1 consecutive cycles.
- A shorter pulse (at least 1 cycle at sync2) produces a glitch increment 1 cycle after sync2 returns to the stable level.
- Every output is a registered output. The block has no handshake and no backpressure.
- Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.

## Test plan
- Reset release with raw_in = 4'b0000: clean_out stays 4'b1000 until cycle filter_len+3 after release. detector_ready (bit 3) then falls, fall_pulse[3] fires exactly once, and no pulse fires at release.
- filter_len = 5, start held high for 20 cycles: clean_out[0] rises exactly 8 cycles after raw_in; rise_pulse[0] is high for 1 cycle; glitch_count[0] = 0.
- filter_len = 5, fg_opto high for 3 cycles, then low: clean_out[1] never rises; glitch_count[1] = 1; repeated 10 times gives 10.
- filter_len = 0, wire_sensor 1-cycle pulse: clean_out[2] high for exactly 1 cycle, 3 cycles after raw_in; rise_pulse and fall_pulse each fire once.
- Glitch counter preloaded near 2^16-1 by repeated short pulses: it saturates at 16'hFFFF. glitch_clear asserted in the same cycle as an increment gives 0.
- filter_len = 100, reset asserted 50 cycles into a qualifying pulse: clean_out returns to RESET_LEVEL, cnt = 0, glitch_count is unchanged, and no pulse fires.
